// File: rtl/mem_unit_nb.sv
// -----------------------------------------------------------------------------
// mem_unit_nb
//   Non-blocking load/store unit. It accepts requests from the LSQ, presents
//   them to an in-order data-memory port in the same cycle and tracks up to
//   MAX_OUTSTANDING requests in a small FIFO. Each memory response pops the
//   oldest entry and produces a CDB writeback: formatted load data, or ROB
//   completion plus a store-tag broadcast for stores. Branch resolution either
//   marks dependent in-flight entries as killed or clears their mask bit.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_*                      LSQ request channel (valid/ready handshake)
//   br_valid/br_mispred/br_bit branch resolution broadcast
//   dmem_gnt, dmem_addr,
//   dmem_rmask/wmask/wdata     memory request (nonzero mask = request)
//   dmem_resp, dmem_rdata      in-order memory response
//   wb_*                       CDB writeback
//   st_tag_valid, st_tag       store-tag broadcast
//   inflight_cnt               number of occupied tracking entries
// -----------------------------------------------------------------------------
module mem_unit_nb #(
    parameter int ROB_DEPTH       = 32,
    parameter int PRF_DEPTH       = 64,
    parameter int BMASK_W         = 4,
    parameter int STAG_W          = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_is_store,
    input  logic [31:0]                          req_addr,
    input  logic [31:0]                          req_wdata,
    input  logic [3:0]                           req_mask,
    input  logic [2:0]                           req_funct3,
    input  logic [$clog2(ROB_DEPTH)-1:0]         req_rob_idx,
    input  logic [$clog2(PRF_DEPTH)-1:0]         req_rd_paddr,
    input  logic [STAG_W-1:0]                    req_stag,
    input  logic [BMASK_W-1:0]                   req_bmask,
    input  logic                                 br_valid,
    input  logic                                 br_mispred,
    input  logic [$clog2(BMASK_W)-1:0]           br_bit,
    input  logic                                 dmem_gnt,
    output logic [31:0]                          dmem_addr,
    output logic [3:0]                           dmem_rmask,
    output logic [3:0]                           dmem_wmask,
    output logic [31:0]                          dmem_wdata,
    input  logic                                 dmem_resp,
    input  logic [31:0]                          dmem_rdata,
    output logic                                 wb_valid,
    output logic                                 wb_is_store,
    output logic [$clog2(ROB_DEPTH)-1:0]         wb_rob_idx,
    output logic [$clog2(PRF_DEPTH)-1:0]         wb_rd_paddr,
    output logic [31:0]                          wb_rd_data,
    output logic                                 st_tag_valid,
    output logic [STAG_W-1:0]                    st_tag,
    output logic [$clog2(MAX_OUTSTANDING):0]     inflight_cnt
);

    localparam int ROB_W = $clog2(ROB_DEPTH);
    localparam int PRF_W = $clog2(PRF_DEPTH);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef struct packed {
        logic               is_store;
        logic [1:0]         off;
        logic [2:0]         funct3;
        logic [ROB_W-1:0]   rob_idx;
        logic [PRF_W-1:0]   rd_paddr;
        logic [STAG_W-1:0]  stag;
        logic [BMASK_W-1:0] bmask;
        logic               killed;
    } entry_t;

    entry_t             r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_kill_in;
    logic               w_not_full;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_dead;
    logic               w_wb;
    entry_t             w_head;
    entry_t             w_new;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;

    // ---------------------------------------------------------------- issue
    assign w_kill_in  = br_valid && br_mispred && req_bmask[br_bit];
    assign w_not_full = (r_cnt < CNT_W'(MAX_OUTSTANDING));

    // Combinational outputs are qualified with rst_n so that every output is
    // 0 while reset is asserted, even though inputs may still be toggling.
    assign req_ready  = rst_n && w_not_full && dmem_gnt;
    assign w_issue    = rst_n && req_valid && w_not_full && !w_kill_in;
    assign w_push     = req_valid && req_ready && !w_kill_in;

    assign dmem_addr  = w_issue ? {req_addr[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = w_issue ? req_wdata : 32'd0;
    assign dmem_wmask = (w_issue &&  req_is_store) ? req_mask : 4'd0;
    assign dmem_rmask = (w_issue && !req_is_store) ? req_mask : 4'd0;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        w_new          = '0;
        w_new.is_store = req_is_store;
        w_new.off      = req_addr[1:0];
        w_new.funct3   = req_funct3;
        w_new.rob_idx  = req_rob_idx;
        w_new.rd_paddr = req_rd_paddr;
        w_new.stag     = req_stag;
        w_new.bmask    = req_bmask;
        // A correctly predicted branch resolving in the accept cycle must not
        // leave a stale dependency bit in the new entry.
        if (br_valid && !br_mispred) begin
            w_new.bmask[br_bit] = 1'b0;
        end
        w_new.killed   = 1'b0;
    end

    // ------------------------------------------------------------- response
    assign w_head = r_fifo[r_head];
    assign w_pop  = rst_n && dmem_resp && (r_cnt != '0);
    // A mispredict in the response cycle itself kills the head as well.
    assign w_dead = w_head.killed || (br_valid && br_mispred && w_head.bmask[br_bit]);
    assign w_wb   = w_pop && !w_dead;

    assign w_byte = dmem_rdata[{w_head.off, 3'b000} +: 8];
    assign w_half = dmem_rdata[{w_head.off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = 32'd0;
        case (w_head.funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            3'b010:  w_load_data = dmem_rdata;
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        wb_valid     = 1'b0;
        wb_is_store  = 1'b0;
        wb_rob_idx   = '0;
        wb_rd_paddr  = '0;
        wb_rd_data   = 32'd0;
        st_tag_valid = 1'b0;
        st_tag       = '0;
        if (w_wb) begin
            wb_valid    = 1'b1;
            wb_is_store = w_head.is_store;
            wb_rob_idx  = w_head.rob_idx;
            if (w_head.is_store) begin
                st_tag_valid = 1'b1;
                st_tag       = w_head.stag;
            end else begin
                wb_rd_paddr = w_head.rd_paddr;
                wb_rd_data  = w_load_data;
            end
        end
    end

    assign inflight_cnt = r_cnt;

    // --------------------------------------------------------- FIFO control
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            // MAX_OUTSTANDING is a power of two, so pointer overflow wraps.
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; occupancy is defined solely by
    // the pointers and count, and a push always overwrites a whole entry.
    // Branch updates are applied to every slot; touching free slots is
    // harmless for the same reason.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (w_push && (r_tail == PTR_W'(i))) begin
                r_fifo[i] <= w_new;
            end else if (br_valid) begin
                if (br_mispred) begin
                    if (r_fifo[i].bmask[br_bit]) begin
                        r_fifo[i].killed <= 1'b1;
                    end
                end else begin
                    r_fifo[i].bmask[br_bit] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_unit_nb.sv
// -----------------------------------------------------------------------------
// tb_mem_unit_nb
//   Scoreboard bench for mem_unit_nb. Each accepted request pushes an expected
//   entry (with the read data the bench will return); each memory response
//   pops the oldest entry and compares the writeback against a reference
//   model of load formatting and branch kill/clear.
// -----------------------------------------------------------------------------
module tb_mem_unit_nb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rob_idx;
    logic [5:0]  req_rd_paddr;
    logic [3:0]  req_stag, req_bmask;
    logic        br_valid, br_mispred;
    logic [1:0]  br_bit;
    logic        dmem_gnt;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_is_store;
    logic [4:0]  wb_rob_idx;
    logic [5:0]  wb_rd_paddr;
    logic [31:0] wb_rd_data;
    logic        st_tag_valid;
    logic [3:0]  st_tag;
    logic [2:0]  inflight_cnt;

    mem_unit_nb dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .req_funct3(req_funct3), .req_rob_idx(req_rob_idx), .req_rd_paddr(req_rd_paddr),
        .req_stag(req_stag), .req_bmask(req_bmask),
        .br_valid(br_valid), .br_mispred(br_mispred), .br_bit(br_bit),
        .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_is_store(wb_is_store), .wb_rob_idx(wb_rob_idx),
        .wb_rd_paddr(wb_rd_paddr), .wb_rd_data(wb_rd_data),
        .st_tag_valid(st_tag_valid), .st_tag(st_tag), .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    logic [49:0]  wb_all;
    logic [125:0] all_out;
    assign wb_all  = {wb_valid, wb_is_store, wb_rob_idx, wb_rd_paddr, wb_rd_data,
                      st_tag_valid, st_tag};
    assign all_out = {req_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, wb_all,
                      inflight_cnt};

    typedef struct {
        logic        is_store;
        logic [4:0]  rob;
        logic [5:0]  rd;
        logic [3:0]  stag;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [3:0]  bmask;
        logic        live;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference load formatting, written with shifts rather than part-selects.
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] rdata);
        logic [31:0] b, h;
        b = rdata >> (32'(off) * 8);
        h = rdata >> (32'(off[1]) * 16);
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'd0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'd0, h[15:0]};
            3'b010:  return rdata;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [49:0] exp_wb(input exp_t e);
        if (!e.live)    return '0;
        if (e.is_store) return {1'b1, 1'b1, e.rob, 6'd0, 32'd0, 1'b1, e.stag};
        return {1'b1, 1'b0, e.rob, e.rd, fmt(e.f3, e.off, e.rdata), 1'b0, 4'd0};
    endfunction

    // Mirror of branch resolution on the expected in-flight entries.
    function automatic void apply_br(input logic mispred, input logic [1:0] bitn);
        foreach (sb[i]) begin
            if (mispred) begin
                if (sb[i].bmask[bitn]) sb[i].live = 1'b0;
            end else begin
                sb[i].bmask[bitn] = 1'b0;
            end
        end
    endfunction

    function automatic void push_sb(input logic [31:0] rdata);
        exp_t e;
        e.is_store = req_is_store;
        e.rob      = req_rob_idx;
        e.rd       = req_rd_paddr;
        e.stag     = req_stag;
        e.f3       = req_funct3;
        e.off      = req_addr[1:0];
        e.bmask    = req_bmask;
        e.live     = 1'b1;
        e.rdata    = rdata;
        sb.push_back(e);
    endfunction

    task automatic idle();
        req_valid = 0; req_is_store = 0; req_addr = 0; req_wdata = 0; req_mask = 0;
        req_funct3 = 0; req_rob_idx = 0; req_rd_paddr = 0; req_stag = 0; req_bmask = 0;
    endtask

    task automatic set_req(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input logic [2:0] f3, input logic [4:0] rob,
                           input logic [5:0] rd, input logic [3:0] stag, input logic [3:0] bm);
        req_valid = 1; req_is_store = st; req_addr = addr; req_wdata = wdata; req_mask = mask;
        req_funct3 = f3; req_rob_idx = rob; req_rd_paddr = rd; req_stag = stag; req_bmask = bm;
    endtask

    // Starts and ends 1 time unit after a rising edge; leaves req_valid high.
    task automatic issue(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic [2:0] f3, input logic [4:0] rob,
                         input logic [5:0] rd, input logic [3:0] stag, input logic [3:0] bm,
                         input logic [31:0] rdata);
        int cyc = 0;
        set_req(st, addr, wdata, mask, f3, rob, rd, stag, bm);
        #1;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #2;
            cyc++;
        end
        n_vec++;
        if (!req_ready) begin
            n_miss++;
            $display("FAIL issue_timeout rob=%0d: req_ready stayed 0 for %0d cycles", rob, cyc);
        end else begin
            @(posedge clk);
            push_sb(rdata);
            #1;
        end
    endtask

    // Returns the oldest response and compares the writeback with the model.
    task automatic respond();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL respond: scoreboard empty");
            return;
        end
        e = sb.pop_front();
        dmem_resp = 1; dmem_rdata = e.rdata;
        #1;
        n_vec++;
        if (wb_all !== exp_wb(e)) begin
            n_miss++;
            $display("FAIL wb rob=%0d: got %h expected %h", e.rob, wb_all, exp_wb(e));
        end
        @(posedge clk); #1;
        dmem_resp = 0; dmem_rdata = 0;
    endtask

    task automatic check_cnt(input string name, input logic [2:0] exp);
        n_vec++;
        if (inflight_cnt !== exp) begin
            n_miss++;
            $display("FAIL %s: inflight_cnt=%0d expected %0d", name, inflight_cnt, exp);
        end
    endtask

    // ------------------------------------------------------------- scenarios
    task automatic test_reset();
        rst_n = 0; dmem_gnt = 1; dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
        br_valid = 0; br_mispred = 0; br_bit = 0;
        set_req(0, 32'h10, 0, 4'hF, 3'b010, 1, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (all_out !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        idle(); dmem_resp = 0; dmem_rdata = 0;
        rst_n = 1;
        @(posedge clk); #1;
        check_cnt("reset_cnt", 0);
    endtask

    task automatic test_lbu();
        set_req(0, 32'h0000_1003, 0, 4'b1000, 3'b100, 1, 7, 0, 0);
        #1;
        n_vec++;
        if ({req_ready, dmem_addr, dmem_rmask, dmem_wmask} !== {1'b1, 32'h1000, 4'b1000, 4'b0000}) begin
            n_miss++;
            $display("FAIL lbu_issue: got ready=%b addr=%h rmask=%b wmask=%b", req_ready,
                     dmem_addr, dmem_rmask, dmem_wmask);
        end
        @(posedge clk);
        push_sb(32'hAB00_0000);
        #1; idle();
        check_cnt("lbu_cnt1", 1);
        @(posedge clk); #1;
        respond();
        check_cnt("lbu_cnt0", 0);
    endtask

    task automatic test_back_to_back();
        dmem_gnt = 0;
        set_req(0, 32'h40, 0, 4'hF, 3'b010, 9, 1, 0, 0);
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL nogrant_ready: got %b expected 0", req_ready);
        end
        @(posedge clk); #1;
        check_cnt("nogrant_cnt", 0);
        dmem_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            issue(0, 32'h100 + 32'(4 * i), 0, 4'hF, 3'b010, 5'(10 + i), 6'(20 + i), 0, 0,
                  32'hC0DE_0000 + 32'(i));
        end
        set_req(0, 32'h200, 0, 4'hF, 3'b010, 14, 24, 0, 0);
        #1;
        check_cnt("full_cnt", 4);
        n_vec++;
        if ({req_ready, dmem_rmask} !== 5'b0) begin
            n_miss++;
            $display("FAIL full_stall: ready=%b rmask=%b expected 0", req_ready, dmem_rmask);
        end
        #(-0) dmem_resp = 1;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL full_with_resp_ready: got %b expected 0", req_ready);
        end
        dmem_resp = 0;
        @(posedge clk); #1;
        respond();
        issue(0, 32'h200, 0, 4'hF, 3'b010, 14, 24, 0, 0, 32'h5555_AAAA);
        idle();
        check_cnt("refill_cnt", 4);
        repeat (4) respond();
        check_cnt("drain_cnt", 0);
    endtask

    task automatic test_store();
        set_req(1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 3'b000, 5, 12, 3, 0);
        #1;
        n_vec++;
        if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata} !==
            {32'h2000, 4'b0000, 4'b0011, 32'hDEAD_BEEF}) begin
            n_miss++;
            $display("FAIL store_issue: addr=%h rmask=%b wmask=%b wdata=%h", dmem_addr,
                     dmem_rmask, dmem_wmask, dmem_wdata);
        end
        @(posedge clk);
        push_sb(32'h0);
        #1; idle();
        respond();
    endtask

    task automatic test_mispred();
        issue(0, 32'h300, 0, 4'hF, 3'b010, 20, 30, 0, 4'b0010, 32'h1111_1111);
        issue(0, 32'h304, 0, 4'hF, 3'b010, 21, 31, 0, 4'b0000, 32'h2222_2222);
        // Mispredict on bit 1 while a dependent store is offered.
        set_req(1, 32'h308, 32'h33, 4'hF, 3'b000, 22, 0, 2, 4'b0010);
        br_valid = 1; br_mispred = 1; br_bit = 1;
        #1;
        n_vec++;
        if ({req_ready, dmem_rmask, dmem_wmask} !== {1'b1, 4'b0, 4'b0}) begin
            n_miss++;
            $display("FAIL kill_in: ready=%b rmask=%b wmask=%b", req_ready, dmem_rmask, dmem_wmask);
        end
        @(posedge clk);
        apply_br(1, 1);
        #1;
        br_valid = 0; br_mispred = 0; idle();
        check_cnt("kill_in_cnt", 2);
        respond();
        respond();
        // Mispredict arriving in the very cycle of the response.
        issue(0, 32'h30C, 0, 4'hF, 3'b010, 23, 32, 0, 4'b0100, 32'h4444_4444);
        idle();
        br_valid = 1; br_mispred = 1; br_bit = 2;
        apply_br(1, 2);
        respond();
        br_valid = 0; br_mispred = 0;
        check_cnt("mispred_cnt", 0);
    endtask

    task automatic test_br_resolve();
        issue(0, 32'h0000_3002, 0, 4'b1100, 3'b001, 7, 9, 0, 4'b0011, 32'h8001_1234);
        // Resolve bit 1 correctly while a second load is being accepted.
        br_valid = 1; br_mispred = 0; br_bit = 1;
        issue(0, 32'h0000_4001, 0, 4'b0010, 3'b100, 8, 10, 0, 4'b0010, 32'h0000_F700);
        apply_br(0, 1);
        br_valid = 0; idle();
        br_valid = 1; br_mispred = 1; br_bit = 1;
        @(posedge clk);
        apply_br(1, 1);
        #1;
        br_valid = 0; br_mispred = 0;
        check_cnt("resolve_cnt", 2);
        respond();
        respond();
    endtask

    task automatic test_formats();
        logic [2:0] f3s  [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        logic [1:0] offs [6] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 6; i++) begin
            issue(0, 32'h500 + 32'(offs[i]), 0, 4'hF, f3s[i], 5'(24 + i), 6'(40 + i), 0, 0,
                  $urandom() | 32'h8080_8080);
            idle();
            respond();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            issue(0, 32'h600 + 32'(4 * i), 0, 4'hF, 3'b010, 5'(i), 6'(i + 1), 0, 0, 32'h77);
        end
        idle();
        check_cnt("pre_reset_cnt", 3);
        set_req(1, 32'h700, 32'h99, 4'hF, 3'b000, 3, 0, 1, 0);
        dmem_resp = 1; dmem_rdata = 32'hFFFF_FFFF;
        #2 rst_n = 0;
        #1;
        n_vec++;
        if (all_out !== '0) begin
            n_miss++;
            $display("FAIL async_reset_outputs: got %h expected 0", all_out);
        end
        sb.delete();
        @(posedge clk); #1;
        idle();
        rst_n = 1;
        #1;
        n_vec++;
        if ({wb_all, inflight_cnt} !== '0) begin
            n_miss++;
            $display("FAIL stale_resp: wb=%h cnt=%0d expected 0", wb_all, inflight_cnt);
        end
        @(posedge clk); #1;
        dmem_resp = 0; dmem_rdata = 0;
        check_cnt("post_reset_cnt", 0);
    endtask

    initial begin
        test_reset();
        test_lbu();
        test_back_to_back();
        test_store();
        test_mispred();
        test_br_resolve();
        test_formats();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
